// File: rtl/operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
//
// EX-stage operand forwarding selector. It picks one of NSRC WIDTH-bit sources
// as the ALU operand. Source 0 is the register-file operand. Sources
// 1..NSRC-1 are forwarding paths.
//
// The block has three pieces of state:
//   - an optional output register (REG_OUT=1) with stall hold and flush;
//   - detection of a select value with no matching source;
//   - a saturating count of forwarded operand uses, for perf monitoring.
//
// Parameters
//   WIDTH   : data width of each source and of out_data
//   NSRC    : number of sources (2..16)
//   SELW    : select width, 2**SELW >= NSRC
//   CNTW    : width of fwd_count
//   REG_OUT : 1 = registered output stage, 0 = combinational output
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_data   : packed sources, source k at [k*WIDTH +: WIDTH]
//   sel       : source select
//   in_valid  : operand this cycle is real (not a bubble)
//   stall     : hold the output stage
//   flush     : kill the output stage contents
//   cnt_clr   : synchronous clear of fwd_count
//   out_data  : selected operand
//   out_valid : out_data is real
//   sel_err   : last accepted select was >= NSRC
//   fwd_count : saturating count of accepted operands with sel != 0
// -----------------------------------------------------------------------------
module operand_fwd_mux #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int CNTW    = 16,
    parameter bit REG_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]       sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  sel_err,
    output logic [CNTW-1:0]       fwd_count
);

    // Unpack the flat source bus into an array so that selection reads cleanly.
    logic [WIDTH-1:0] src [NSRC];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign src[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A select with no matching source falls back to the register-file
    // operand, so the ALU still gets a sane value while the error is flagged.
    logic sel_oor;
    assign sel_oor = (32'(sel) >= 32'(NSRC));

    logic [WIDTH-1:0] pick;
    always_comb begin
        pick = src[0];
        for (int k = 1; k < NSRC; k++) begin
            if (32'(sel) == 32'(k)) begin
                pick = src[k];
            end
        end
    end

    // An operand is consumed only when it is real, the stage is not held,
    // and the stage is not being killed.
    logic accept;
    logic fwd_hit;
    assign accept  = in_valid & ~stall & ~flush;
    assign fwd_hit = accept & (sel != '0);

    // Forwarding-use counter. It saturates instead of wrapping, so a long run
    // never reads back as a small value. A clear wins over a same-cycle hit.
    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (fwd_hit && (cnt_reg != {CNTW{1'b1}})) begin
            cnt_reg <= cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign fwd_count = cnt_reg;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;
            logic             err_reg;

            // Priority: flush > stall > load. A bubble (in_valid=0) clears
            // valid but keeps the last real data on the bus.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (flush) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (!stall) begin
                    valid_reg <= in_valid;
                    err_reg   <= in_valid & sel_oor;
                    if (in_valid) begin
                        data_reg <= pick;
                    end
                end
            end

            assign out_data  = data_reg;
            assign out_valid = valid_reg;
            assign sel_err   = err_reg;
        end else begin : g_comb_out
            // Legacy zero-latency path. Stall has no effect here. It only
            // gates the counter through accept.
            assign out_data  = pick;
            assign out_valid = in_valid & ~flush;
            assign sel_err   = in_valid & sel_oor;
        end
    endgenerate

endmodule

// File: tb/tb_operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// tb_operand_fwd_mux
//
// This bench drives three instances from the same control inputs:
//   A : NSRC=4, CNTW=16, registered output
//   B : NSRC=3, CNTW=2,  registered output (out-of-range select, saturation)
//   C : NSRC=3, CNTW=4,  combinational output
//
// A reference model holds the expected output register contents and the
// counter values. The bench updates it on every rising edge and compares it
// with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_operand_fwd_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src [4];
    logic [1:0]  sel;
    logic        in_valid, stall, flush, cnt_clr;

    logic [127:0] in_data_a;
    logic [95:0]  in_data_bc;
    assign in_data_a  = {src[3], src[2], src[1], src[0]};
    assign in_data_bc = {src[2], src[1], src[0]};

    logic [31:0] a_out_data, b_out_data, c_out_data;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic        a_sel_err, b_sel_err, c_sel_err;
    logic [15:0] a_fwd_count;
    logic [1:0]  b_fwd_count;
    logic [3:0]  c_fwd_count;

    operand_fwd_mux #(.WIDTH(32), .NSRC(4), .SELW(2), .CNTW(16), .REG_OUT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .out_data(a_out_data),
        .out_valid(a_out_valid), .sel_err(a_sel_err), .fwd_count(a_fwd_count));

    operand_fwd_mux #(.WIDTH(32), .NSRC(3), .SELW(2), .CNTW(2), .REG_OUT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_bc), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .out_data(b_out_data),
        .out_valid(b_out_valid), .sel_err(b_sel_err), .fwd_count(b_fwd_count));

    operand_fwd_mux #(.WIDTH(32), .NSRC(3), .SELW(2), .CNTW(4), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_bc), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr), .out_data(c_out_data),
        .out_valid(c_out_valid), .sel_err(c_sel_err), .fwd_count(c_fwd_count));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: index 0 = A, 1 = B for the output stage; 0..2 = A,B,C for counters.
    logic [31:0] md [2];
    logic        mv [2];
    logic        me [2];
    int          mc [3];
    int          mn   [3] = '{4, 3, 3};
    int          mmax [3] = '{65535, 3, 15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pick(input int n);
        int s;
        s = int'(sel);
        return (s < n) ? src[s] : src[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md[i] = '0; mv[i] = 1'b0; me[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) mc[i] = 0;
    endtask

    task automatic model_edge();
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = in_valid && !stall && !flush;
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                md[i] = '0; mv[i] = 1'b0; me[i] = 1'b0;
            end else if (!stall) begin
                mv[i] = in_valid;
                me[i] = in_valid && (int'(sel) >= mn[i]);
                if (in_valid) md[i] = pick(mn[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (cnt_clr) mc[i] = 0;
            else if (acc && sel != 2'd0 && mc[i] < mmax[i]) mc[i] = mc[i] + 1;
        end
    endtask

    task automatic check_regs();
        check("a_data",  a_out_data,  md[0]);
        check("a_valid", 32'(a_out_valid), 32'(mv[0]));
        check("a_err",   32'(a_sel_err),   32'(me[0]));
        check("b_data",  b_out_data,  md[1]);
        check("b_valid", 32'(b_out_valid), 32'(mv[1]));
        check("b_err",   32'(b_sel_err),   32'(me[1]));
        check("a_cnt",   32'(a_fwd_count), 32'(mc[0]));
        check("b_cnt",   32'(b_fwd_count), 32'(mc[1]));
        check("c_cnt",   32'(c_fwd_count), 32'(mc[2]));
    endtask

    // Inputs are already applied. First check the combinational instance,
    // then take one edge, update the model and check every registered output.
    task automatic cycle();
        #1;
        check("c_data",  c_out_data, pick(3));
        check("c_valid", 32'(c_out_valid), 32'(in_valid && !flush));
        check("c_err",   32'(c_sel_err),   32'(in_valid && (int'(sel) >= 3)));
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_regs();
        $display("cyc %0d sel %0d v %0b st %0b fl %0b clr %0b | a %h/%0b/%0b/%0d b %h/%0b/%0b/%0d c %0d",
                 cyc, sel, in_valid, stall, flush, cnt_clr,
                 a_out_data, a_out_valid, a_sel_err, a_fwd_count,
                 b_out_data, b_out_valid, b_sel_err, b_fwd_count, c_fwd_count);
    endtask

    task automatic drive(input logic [1:0] s, input logic v, input logic st,
                         input logic fl, input logic clr);
        sel = s; in_valid = v; stall = st; flush = fl; cnt_clr = clr;
    endtask

    int saved;
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) src[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst = 1'b0;

        // Sweep the selects. The data appears one cycle later.
        src[0] = 32'h11111111; src[1] = 32'h22222222;
        src[2] = 32'h33333333; src[3] = 32'h44444444;
        for (int k = 0; k < 4; k++) begin
            drive(2'(k), 1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
            check("sweep_data", a_out_data, 32'h11111111 * (k + 1));
            check("sweep_valid", 32'(a_out_valid), 32'd1);
        end
        check("sweep_cnt", 32'(a_fwd_count), 32'd3);

        // Stall hold.
        drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        saved = int'(a_fwd_count);
        for (int k = 0; k < 3; k++) begin
            drive(2'(k), 1'b1, 1'b1, 1'b0, 1'b0);
            src[k] = $urandom;
            cycle();
            check("stall_data", a_out_data, 32'h33333333);
            check("stall_cnt", 32'(a_fwd_count), 32'(saved));
        end
        drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        src[1] = 32'hCAFEF00D;
        cycle();
        check("unstall_data", a_out_data, 32'hCAFEF00D);

        // Stall and flush together: flush wins.
        drive(2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        check("flush_data", a_out_data, 32'd0);
        check("flush_valid", 32'(a_out_valid), 32'd0);
        saved = int'(a_fwd_count);
        drive(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        check("flush_nocnt", 32'(a_fwd_count), 32'(saved));

        // Out-of-range select on B (NSRC=3).
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        src[0] = 32'hDEADBEEF;
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("oor_data", b_out_data, 32'hDEADBEEF);
        check("oor_err", 32'(b_sel_err), 32'd1);
        check("oor_cnt", 32'(b_fwd_count), 32'd1);
        drive(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("oor_err_clr", 32'(b_sel_err), 32'd0);

        // B counter saturation, then a clear that wins over an accepted forward.
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
            check("sat_cnt", 32'(b_fwd_count), 32'(sat_exp[k]));
        end
        drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        check("clr_cnt", 32'(b_fwd_count), 32'd0);

        // Build a count of 5 on A, then assert an async reset mid-stall.
        for (int k = 0; k < 5; k++) begin
            drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("pre_rst_cnt", 32'(a_fwd_count), 32'd5);
        drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_cnt",   32'(a_fwd_count), 32'd0);
        check("arst_data",  a_out_data, 32'd0);
        check("arst_valid", 32'(a_out_valid), 32'd0);
        check_regs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) src[i] = $urandom;
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 19) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fwd_mux.md
# operand_fwd_mux

Parametrised operand-forwarding selector for the EX stage of the pipelined MIPS datapath. It generalises the fixed 32-bit 4:1 forwarding mux to NSRC sources of WIDTH bits, and adds the following:
- a registered output stage with stall hold and flush;
- out-of-range select detection;
- a saturating count of forwarded (non-register-file) operand uses, for performance monitoring.

It sits between the ID/EX operand sources and the ALU input.

## Interface
- WIDTH, 32, data width of each source and of out_data
- NSRC, 4, number of sources (2..16); source 0 is the register-file operand, sources 1..NSRC-1 are forwarding paths
- SELW, 2, width of sel; must satisfy 2**SELW >= NSRC
- CNTW, 16, width of fwd_count
- REG_OUT, 1, 1 = registered output stage; 0 = combinational out_data (legacy behaviour)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_data  input  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SELW  source select
- in_valid  input  1  operand in this cycle is real (not a bubble)
- stall  input  1  hold the output stage
- flush  input  1  kill the output stage contents
- cnt_clr  input  1  synchronous clear of fwd_count
- out_data  output  WIDTH  selected operand
- out_valid  output  1  out_data is real
- sel_err  output  1  registered flag: last accepted select was >= NSRC
- fwd_count  output  CNTW  saturating count of accepted operands with sel != 0

## Operation
- Selection: pick = in_data[sel*WIDTH +: WIDTH] when sel < NSRC.
  - When sel >= NSRC: pick = source 0, and the error is flagged.
- "Accept" means: in_valid=1, stall=0 and flush=0 in the same cycle.
- REG_OUT=1 stage registers, updated each rising edge with priority rst > flush > stall > load:
  - flush: out_data <= 0, out_valid <= 0, sel_err <= 0.
  - stall (no flush): all stage registers hold.
  - otherwise: out_valid <= in_valid and sel_err <= in_valid & (sel >= NSRC).
    - out_data <= pick only when in_valid=1; when in_valid=0, out_data holds its previous value.
- REG_OUT=0:
  - out_data = pick, combinationally.
  - out_valid = in_valid & ~flush.
  - sel_err = in_valid & (sel >= NSRC), combinationally.
  - stall has no effect on these outputs.
- fwd_count, registered in both modes:
  - rst → 0; cnt_clr → 0 (cnt_clr has priority over increment).
  - Increments by 1 on each accepted cycle with sel != 0, including out-of-range selects.
  - Saturates at 2**CNTW-1 and never wraps.
- No state machine. The block is a data register, a valid/error register and a counter.

## Timing
- Reset (async, takes effect immediately): out_data=0, out_valid=0, sel_err=0, fwd_count=0.
- Release of rst is sampled on the next rising edge of clk.
- REG_OUT=1 latency is 1 cycle: a source accepted at edge N appears on out_data/out_valid after edge N.
- REG_OUT=0 latency is 0 cycles for data, valid and error.
- A stall lasting k cycles holds out_data/out_valid/sel_err for exactly those k edges.
  - The first load after the stall takes the inputs present in the cycle stall is low.
- Simultaneous stall and flush: flush wins, and the output becomes a bubble.
- Simultaneous flush and in_valid: not accepted, and the counter does not increment.
- Counter at saturation with an accepted forward: stays at 2**CNTW-1.
- cnt_clr together with an accepted forward: the counter becomes 0, not 1.
- rst asserted mid-stall: all outputs go to 0 immediately, and the hold is abandoned.

## Test plan
- Reset and select sweep:
  - Stimulus: rst pulse, then sources {0x11111111, 0x22222222, 0x33333333, 0x44444444}, with sel = 0,1,2,3 on consecutive cycles and in_valid=1.
  - Required response: out_data shows the same sequence one cycle later, out_valid=1 throughout, and fwd_count=3.
- Stall hold:
  - Stimulus: load sel=2, then stall=1 for 3 cycles while sel/in_data change.
  - Required response: out_data stays 0x33333333 for 3 cycles, then takes the new pick on the first unstalled edge; fwd_count does not move during the stall.
- Flush priority:
  - Stimulus: stall=1 and flush=1 together while out_valid=1.
  - Required response: next cycle out_data=0 and out_valid=0.
  - Stimulus: flush=1 with in_valid=1 and sel=1.
  - Required response: no count increment.
- Out-of-range select:
  - Stimulus: NSRC=3, SELW=2, sel=3, in_valid=1, source0=0xDEADBEEF.
  - Required response: out_data=0xDEADBEEF, sel_err=1 for one cycle, fwd_count +1.
- Counter saturation and clear:
  - Stimulus: CNTW=2, five accepted cycles with sel=1.
  - Required response: fwd_count sequence 1,2,3,3,3.
  - Stimulus: cnt_clr together with an accepted forward.
  - Required response: fwd_count=0.
- Combinational mode and async reset:
  - Stimulus: REG_OUT=0, sel=1.
  - Required response: out_data equals source 1 in the same cycle.
  - Stimulus: rst asserted between clock edges while fwd_count=5.
  - Required response: fwd_count and all registered outputs read 0 before the next edge.
